mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Sits between the pipeline's two memory clients (port 0 = icache, port 1 = dcache) and the unified
//  tagged memory (`mem`). Picks one client per cycle to drive proc2mem_*, forwards the memory's
//  accept tag to that client, records which client owns each outstanding load tag, and routes
//  mem2proc_data/tag back to the owning client when it returns.
// PARAMETERS
//  NTAG   16  tag space size; tag 0 = "no tag"/reject, so tags 1..NTAG-1 are usable (tag width 4)
// PORTS
//  clock             in   1      system clock
//  reset             in   1      synchronous, active-low reset
//  c_command[1:0]    in   2x2    per-client BUS_NONE/BUS_LOAD/BUS_STORE request
//  c_addr[1:0]       in   2x32   per-client byte address
//  c_data[1:0]       in   2x64   per-client store data
//  c_response[1:0]   out  2x4    accept tag to client; 0 = not accepted this cycle
//  c_rdata[1:0]      out  2x64   load data returned to client
//  c_rtag[1:0]       out  2x4    returning tag for client; 0 = nothing returned
//  proc2mem_command  out  2      command to memory
//  proc2mem_addr     out  32     address to memory
//  proc2mem_data     out  64     store data to memory
//  mem2proc_response in   4      memory accept tag (0 = rejected)
//  mem2proc_data     in   64     load data from memory
//  mem2proc_tag      in   4      returning load tag (0 = none)
//  orphan_err        out  1      sticky: a tag returned with no recorded owner
// BEHAVIOUR
//  - Request path is combinational (memory answers in the same cycle): winner's command/addr/data
//    drive proc2mem_*; loser sees c_response=0 and must hold its request. No request -> BUS_NONE,
//    addr/data 0.
//  - Arbitration: one client requesting -> it wins. Both requesting -> rr_ptr picks winner.
//    rr_ptr (1 bit) flips to the other client only on a cycle the winner is accepted
//    (mem2proc_response!=0); rejected cycles leave rr_ptr unchanged (no starvation).
//  - c_response[winner] = mem2proc_response; c_response[loser] = 0.
//  - Owner table: NTAG entries {valid, owner}. On accepted BUS_LOAD, entry[mem2proc_response] <=
//    {1, winner} at posedge. Accepted BUS_STORE allocates nothing.
//  - Return path combinational: mem2proc_tag!=0 and entry valid -> c_rtag[owner]=mem2proc_tag,
//    c_rdata[owner]=mem2proc_data; other client gets c_rtag=0, c_rdata=0. Entry cleared at posedge.
//  - Return tag with invalid entry (incl. store tags) -> dropped, orphan_err set (sticky until reset).
//  - Same tag returned and re-accepted in the same cycle -> allocation wins; entry ends valid with new owner.
//  - mem2proc_tag==0 -> no return, no table change. Tag 0 entry never written.
//  - Reset (reset==0 at posedge): all entries invalid, rr_ptr=0 (icache first), orphan_err=0.
//    Outputs are combinational from state; while reset asserted proc2mem_command forced BUS_NONE,
//    c_response=0, c_rtag=0. Loads outstanding at reset are forgotten; their later returns set orphan_err.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stall_cnt[1:0] (2x32) and load_cnt[1:0] (2x32).
//    stall_cnt[i] += 1 each cycle client i requests and c_response[i]==0;
//    load_cnt[i] += 1 per accepted load. Saturating at 2^32-1; cleared on reset.
//  ARB_STATS_EN undefined: no counters, no extra ports; behaviour otherwise identical.
// TESTING
//  1. reset=0 two cycles, both clients idle -> proc2mem_command=BUS_NONE, all c_rtag=0, orphan_err=0.
//  2. Icache only, BUS_LOAD 0x100, mem responds 3; 5 cycles later tag 3, data 0xDEAD_BEEF ->
//     c_response[0]=3 that cycle; c_rtag[0]=3, c_rdata[0]=0xDEAD_BEEF; c_rtag[1]=0.
//  3. Both load every cycle, memory always accepts (tags 1,2,3,4) -> winners 0,1,0,1;
//     each returned tag routed to the client that issued it.
//  4. Both request, memory rejects 3 cycles then accepts tag 7 -> icache wins all 4 cycles,
//     dcache c_response=0 throughout; cycle 5 dcache wins.
//  5. Dcache BUS_STORE accepted tag 5; later mem2proc_tag=5 -> no client sees tag, orphan_err=1.
//  6. Tag 2 returning to icache while dcache load accepted as tag 2 same cycle -> icache gets
//     data; next return of tag 2 goes to dcache. With ARB_STATS_EN, check stall_cnt after test 4 = {3,4}
//     ({icache, dcache}).

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and the tagged memory.
// The master modport is the arbiter's view; the slave modport is the environment's view (clients + memory).
interface mem_bus_arbiter_if;
  logic [1:0][1:0]  c_command;
  logic [1:0][31:0] c_addr;
  logic [1:0][63:0] c_data;
  logic [1:0][3:0]  c_response;
  logic [1:0][63:0] c_rdata;
  logic [1:0][3:0]  c_rtag;

  logic [1:0]       proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [3:0]       mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [3:0]       mem2proc_tag;

  modport master (
    input  c_command, c_addr, c_data, mem2proc_response, mem2proc_data, mem2proc_tag,
    output c_response, c_rdata, c_rtag, proc2mem_command, proc2mem_addr, proc2mem_data
  );

  modport slave (
    output c_command, c_addr, c_data, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  c_response, c_rdata, c_rtag, proc2mem_command, proc2mem_addr, proc2mem_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-client (icache=0, dcache=1) arbiter onto a tagged memory, with per-tag owner tracking for load returns.
// Optional ARB_STATS_EN macro adds saturating per-client stall and load counters.
module mem_bus_arbiter #(
  parameter int NTAG = 16
) (
  input  logic clock,
  input  logic reset,
  mem_bus_arbiter_if.master bus,
  output logic orphan_err
`ifdef ARB_STATS_EN
  ,
  output logic [1:0][31:0] stall_cnt,
  output logic [1:0][31:0] load_cnt
`endif
);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  logic [NTAG-1:0] tag_valid;
  logic            owner_tbl [NTAG];
  logic            rr_ptr;

  logic [1:0] req;
  logic       grant;
  logic       winner;
  logic       accepted;
  logic       alloc;
  logic       ret_valid;
  logic       ret_owner;
  logic       orphan_hit;

  // Arbitration and return-path decode; every path is gated while reset is held low.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, otherwise a latch is inferred.
    req[0]     = bus.c_command[0] != BUS_NONE;
    req[1]     = bus.c_command[1] != BUS_NONE;
    grant      = reset && (req != 2'b00);
    winner     = (req == 2'b11) ? rr_ptr : req[1];
    accepted   = grant && (bus.mem2proc_response != 4'd0);
    alloc      = accepted && (bus.c_command[winner] == BUS_LOAD);
    ret_valid  = reset && (bus.mem2proc_tag != 4'd0) && tag_valid[bus.mem2proc_tag];
    orphan_hit = reset && (bus.mem2proc_tag != 4'd0) && !tag_valid[bus.mem2proc_tag];
    ret_owner  = owner_tbl[bus.mem2proc_tag];
  end

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.c_response       = '0;
    bus.c_rtag           = '0;
    bus.c_rdata          = '0;
    if (grant) begin
      bus.proc2mem_command      = bus.c_command[winner];
      bus.proc2mem_addr         = bus.c_addr[winner];
      bus.proc2mem_data         = bus.c_data[winner];
      bus.c_response[winner]    = bus.mem2proc_response;
    end
    if (ret_valid) begin
      bus.c_rtag[ret_owner]  = bus.mem2proc_tag;
      bus.c_rdata[ret_owner] = bus.mem2proc_data;
    end
  end

  // The allocation is written after the clear so a tag returned and re-issued in one cycle stays valid.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      tag_valid  <= '0;
      rr_ptr     <= 1'b0;
      orphan_err <= 1'b0;
    end else begin
      if (ret_valid)  tag_valid[bus.mem2proc_tag]      <= 1'b0;
      if (alloc)      tag_valid[bus.mem2proc_response] <= 1'b1;
      if (accepted)   rr_ptr                           <= ~winner;
      if (orphan_hit) orphan_err                       <= 1'b1;
    end
  end

  // NOTE: the owner table is deliberately not reset; tag_valid alone decides whether an entry means anything.
  always_ff @(posedge clock) begin
    if (alloc) owner_tbl[bus.mem2proc_response] <= winner;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
      load_cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req[i] && (bus.c_response[i] == 4'd0) && (stall_cnt[i] != 32'hFFFF_FFFF))
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
        if (alloc && (winner == 1'(i)) && (load_cnt[i] != 32'hFFFF_FFFF))
          load_cnt[i] <= load_cnt[i] + 32'd1;
      end
    end
  end
`else
  // Statistics hardware is absent in this build.
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a driver applies directed and random cycles, a reference model
// pushes the expected outputs per cycle, and a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic orphan_err;
`ifdef ARB_STATS_EN
  logic [1:0][31:0] stall_cnt;
  logic [1:0][31:0] load_cnt;
`endif

  mem_bus_arbiter_if bus();

  mem_bus_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .orphan_err (orphan_err)
`ifdef ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .load_cnt   (load_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string            nm;
    bit               in_rst;
    logic [1:0]       cmd;
    logic [31:0]      addr;
    logic [63:0]      data;
    logic [1:0][3:0]  resp;
    logic [1:0][3:0]  rtag;
    logic [1:0][63:0] rdata;
    logic             orphan;
    logic [1:0][31:0] stall;
    logic [1:0][31:0] loads;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: tag -> owning client, round-robin preference, sticky orphan flag, counters.
  int          m_owner[int];
  int          m_pref   = 0;
  bit          m_orphan = 1'b0;
  logic [31:0] m_stall[2];
  logic [31:0] m_loads[2];

  int pend[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input string nm, input bit rst,
                     input logic [1:0] k0, input logic [31:0] a0, input logic [63:0] d0,
                     input logic [1:0] k1, input logic [31:0] a1, input logic [63:0] d1,
                     input logic [3:0] resp, input logic [3:0] rt, input logic [63:0] rd,
                     output int w, output bit acc);
    exp_t e;
    bit r0, r1;
    logic [1:0] kw;
    reset                 = !rst;
    bus.c_command[0]      = k0;
    bus.c_addr[0]         = a0;
    bus.c_data[0]         = d0;
    bus.c_command[1]      = k1;
    bus.c_addr[1]         = a1;
    bus.c_data[1]         = d1;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag      = rt;
    bus.mem2proc_data     = rd;

    r0  = (k0 != NONE);
    r1  = (k1 != NONE);
    w   = (r0 && r1) ? m_pref : (r1 ? 1 : 0);
    kw  = (w == 1) ? k1 : k0;
    acc = !rst && (r0 || r1) && (resp != 4'd0);

    e.nm       = nm;
    e.in_rst   = rst;
    e.cmd      = NONE;
    e.addr     = '0;
    e.data     = '0;
    e.resp     = '0;
    e.rtag     = '0;
    e.rdata    = '0;
    e.orphan   = m_orphan;
    e.stall[0] = m_stall[0];
    e.stall[1] = m_stall[1];
    e.loads[0] = m_loads[0];
    e.loads[1] = m_loads[1];

    if (!rst) begin
      if (r0 || r1) begin
        e.cmd     = kw;
        e.addr    = (w == 1) ? a1 : a0;
        e.data    = (w == 1) ? d1 : d0;
        e.resp[w] = resp;
      end
      if (rt != 4'd0) begin
        if (m_owner.exists(int'(rt))) begin
          e.rtag[m_owner[int'(rt)]]  = rt;
          e.rdata[m_owner[int'(rt)]] = rd;
          m_owner.delete(int'(rt));
        end else begin
          m_orphan = 1'b1;
        end
      end
      if (acc) begin
        if (kw == LOAD) begin
          m_owner[int'(resp)] = w;
          if (m_loads[w] != 32'hFFFF_FFFF) m_loads[w]++;
        end
        m_pref = 1 - w;
      end
      if (r0 && e.resp[0] == 4'd0 && m_stall[0] != 32'hFFFF_FFFF) m_stall[0]++;
      if (r1 && e.resp[1] == 4'd0 && m_stall[1] != 32'hFFFF_FFFF) m_stall[1]++;
    end else begin
      m_owner.delete();
      m_pref     = 0;
      m_orphan   = 1'b0;
      m_stall[0] = '0;
      m_stall[1] = '0;
      m_loads[0] = '0;
      m_loads[1] = '0;
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string nm, input logic [3:0] rt, input logic [63:0] rd);
    int w;
    bit acc;
    cyc(nm, 1'b0, NONE, 0, 0, NONE, 0, 0, 4'd0, rt, rd, w, acc);
  endtask

  task automatic do_reset(input int n);
    int w;
    bit acc;
    for (int i = 0; i < n; i++) cyc("reset", 1'b1, NONE, 0, 0, NONE, 0, 0, 4'd0, 4'd0, 0, w, acc);
    pend.delete();
  endtask

  function automatic bit in_pend(input int t);
    for (int i = 0; i < pend.size(); i++) if (pend[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.nm, " cmd"}, 64'(bus.proc2mem_command), 64'(e.cmd));
        if (!e.in_rst) begin
          check({e.nm, " addr"}, 64'(bus.proc2mem_addr), 64'(e.addr));
          check({e.nm, " data"}, bus.proc2mem_data, e.data);
        end
        check({e.nm, " resp0"},  64'(bus.c_response[0]), 64'(e.resp[0]));
        check({e.nm, " resp1"},  64'(bus.c_response[1]), 64'(e.resp[1]));
        check({e.nm, " rtag0"},  64'(bus.c_rtag[0]), 64'(e.rtag[0]));
        check({e.nm, " rtag1"},  64'(bus.c_rtag[1]), 64'(e.rtag[1]));
        check({e.nm, " rdata0"}, bus.c_rdata[0], e.rdata[0]);
        check({e.nm, " rdata1"}, bus.c_rdata[1], e.rdata[1]);
        check({e.nm, " orphan"}, 64'(orphan_err), 64'(e.orphan));
`ifdef ARB_STATS_EN
        check({e.nm, " stall0"}, 64'(stall_cnt[0]), 64'(e.stall[0]));
        check({e.nm, " stall1"}, 64'(stall_cnt[1]), 64'(e.stall[1]));
        check({e.nm, " loads0"}, 64'(load_cnt[0]), 64'(e.loads[0]));
        check({e.nm, " loads1"}, 64'(load_cnt[1]), 64'(e.loads[1]));
`endif
      end
    end
  end

  initial begin
    int          w;
    bit          acc;
    logic [1:0]  k[2];
    logic [31:0] a[2];
    logic [63:0] d[2];
    bit          held[2];
    int          free[$];
    logic [3:0]  resp, rt;
    logic [63:0] rd;

    m_stall[0] = '0; m_stall[1] = '0; m_loads[0] = '0; m_loads[1] = '0;
    bus.c_command = '0; bus.c_addr = '0; bus.c_data = '0;
    bus.mem2proc_response = '0; bus.mem2proc_tag = '0; bus.mem2proc_data = '0;
    @(posedge clock);
    #1;

    do_reset(2);

    // Single icache load, returned five cycles later.
    cyc("t2_load", 1'b0, LOAD, 32'h100, 0, NONE, 0, 0, 4'd3, 4'd0, 0, w, acc);
    repeat (4) idle("t2_wait", 4'd0, 0);
    idle("t2_ret", 4'd3, 64'hDEAD_BEEF);

    // Both clients load every cycle; grants alternate and returns route to the issuer.
    do_reset(1);
    for (int i = 0; i < 4; i++)
      cyc("t3_both", 1'b0, LOAD, 32'h1000 + 32'(i), 64'(i), LOAD, 32'h2000 + 32'(i), 64'(i),
          4'(i + 1), 4'd0, 0, w, acc);
    for (int i = 4; i >= 1; i--) idle("t3_ret", 4'(i), 64'h1111_0000 + 64'(i));

    // Rejections keep the grant on icache; dcache goes next.
    do_reset(1);
    cyc("t4_rej", 1'b0, LOAD, 32'h300, 0, LOAD, 32'h400, 0, 4'd0, 4'd0, 0, w, acc);
    cyc("t4_rej", 1'b0, LOAD, 32'h300, 0, LOAD, 32'h400, 0, 4'd0, 4'd0, 0, w, acc);
    cyc("t4_rej", 1'b0, LOAD, 32'h300, 0, LOAD, 32'h400, 0, 4'd0, 4'd0, 0, w, acc);
    cyc("t4_acc", 1'b0, LOAD, 32'h300, 0, LOAD, 32'h400, 0, 4'd7, 4'd0, 0, w, acc);
    cyc("t4_d",   1'b0, NONE, 0, 0, LOAD, 32'h400, 0, 4'd8, 4'd0, 0, w, acc);
    idle("t4_ret7", 4'd7, 64'h77);
    idle("t4_ret8", 4'd8, 64'h88);

    // Store tag returning is an orphan.
    cyc("t5_store", 1'b0, NONE, 0, 0, STORE, 32'h500, 64'h55, 4'd5, 4'd0, 0, w, acc);
    idle("t5_gap", 4'd0, 0);
    idle("t5_ret", 4'd5, 64'h5555);
    idle("t5_sticky", 4'd0, 0);

    // Same tag returned to icache and re-issued to dcache in one cycle.
    cyc("t6_i", 1'b0, LOAD, 32'h600, 0, NONE, 0, 0, 4'd2, 4'd0, 0, w, acc);
    cyc("t6_swap", 1'b0, NONE, 0, 0, LOAD, 32'h700, 0, 4'd2, 4'd2, 64'hAAAA, w, acc);
    idle("t6_gap", 4'd0, 0);
    idle("t6_ret_d", 4'd2, 64'hBBBB);

    // A load outstanding across reset is forgotten.
    cyc("t7_load", 1'b0, LOAD, 32'h900, 0, NONE, 0, 0, 4'd9, 4'd0, 0, w, acc);
    do_reset(1);
    idle("t7_ret", 4'd9, 64'h99);
    idle("t7_sticky", 4'd0, 0);

    // Randomized traffic with held requests and out-of-order returns.
    do_reset(1);
    held[0] = 1'b0; held[1] = 1'b0;
    k[0] = NONE; k[1] = NONE; a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!held[i]) begin
          if ($urandom_range(0, 9) < 6) k[i] = ($urandom_range(0, 9) < 7) ? LOAD : STORE;
          else k[i] = NONE;
          a[i] = $urandom;
          d[i] = {$urandom, $urandom};
        end
      end
      rt = '0;
      rd = '0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        int j;
        j  = $urandom_range(0, pend.size() - 1);
        rt = 4'(pend[j]);
        pend.delete(j);
        rd = {$urandom, $urandom};
      end
      resp = '0;
      if ((k[0] != NONE || k[1] != NONE) && $urandom_range(0, 3) != 0) begin
        free.delete();
        for (int t = 1; t < 16; t++) if (!in_pend(t)) free.push_back(t);
        if (free.size() > 0) resp = 4'(free[$urandom_range(0, free.size() - 1)]);
      end
      cyc("rand", 1'b0, k[0], a[0], d[0], k[1], a[1], d[1], resp, rt, rd, w, acc);
      if (acc && k[w] == LOAD) pend.push_back(int'(resp));
      for (int i = 0; i < 2; i++) held[i] = (k[i] != NONE) && !(acc && w == i);
    end
    while (pend.size() > 0) begin
      rt = 4'(pend.pop_front());
      idle("drain", rt, {$urandom, $urandom});
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
